dm_host_ctrl: RTL and testbench
===============================

# dm_host_ctrl

Host-side sequencer for the processor's external data-memory port. It loads a byte stream into data memory, runs the processor until `end_process`, then reads the result region back out as a byte stream. It drives the processor's `status`, `data_in` and `data_addr_in` inputs and consumes `end_process` and `dm_out`, making it the initiating end of that interface. It sits between the top-level stream source/sink (e.g. a UART wrapper) and `processor`.

## Interface
Parameters:
- `LOAD_BASE`, 16'h0000: first data-memory address written during load.
- `LOAD_WORDS`, 16: bytes per load; must be ≥1.
- `UNLOAD_BASE`, 16'h0000: first data-memory address read during unload.
- `UNLOAD_WORDS`, 16: bytes per unload; must be ≥1.
- `READ_LAT`, 2: cycles from the edge that registers `data_addr_in` to a valid `dm_out`; must be ≥1.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins one load/run/unload job; sampled only in IDLE.
- `in_valid`  in  1  load byte available.
- `in_data`  in  8  load byte.
- `in_ready`  out  1  block accepts a load byte.
- `out_valid`  out  1  unload byte available.
- `out_data`  out  8  unload byte.
- `out_ready`  in  1  sink accepts the unload byte.
- `status`  out  2  to processor: 00 hold, 01 run, 10 load write, 11 unload read.
- `data_in`  out  8  to processor: byte to write.
- `data_addr_in`  out  16  to processor: DM address.
- `end_process`  in  1  from processor: program finished.
- `dm_out`  in  8  from processor data memory.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a job completes.
- `run_cycles`  out  32  cycles spent in RUN for the last or current job.

## Operation
States: IDLE, LOAD, LOAD_GAP, RUN, UL_ADDR, UL_WAIT, UL_OUT, DONE.
- IDLE: `status`=00, `in_ready`=0. On `start`=1: clear the counter, clear `run_cycles`, go to LOAD.
- LOAD: `in_ready`=1.
  - On an `in_valid && in_ready` handshake, register `data_in`<=`in_data`, `data_addr_in`<=`LOAD_BASE`+count (mod 2^16), and `status`<=10 for exactly that next cycle. Then increment the count.
  - Cycles with no handshake drive `status`=00.
  - After byte `LOAD_WORDS`-1 is accepted, go to LOAD_GAP with `in_ready`=0.
- LOAD_GAP: one cycle, `status`=00, so the last write completes. Then go to RUN.
- RUN: `status`=01, `run_cycles` increments each cycle and saturates at all-ones. On `end_process`=1, `status`<=00, clear the counter, go to UL_ADDR.
- UL_ADDR: `status`<=11, `data_addr_in`<=`UNLOAD_BASE`+count (mod 2^16), go to UL_WAIT.
- UL_WAIT: hold for `READ_LAT` cycles. Then capture `dm_out` into `out_data`, set `out_valid`=1, go to UL_OUT.
- UL_OUT: hold `out_data`/`out_valid` until `out_ready`=1.
  - On the handshake, drop `out_valid`.
  - If this was the last byte, go to DONE; otherwise increment the count and go to UL_ADDR.
- DONE: `done`=1 for one cycle, `status`=00, return to IDLE.
- `status` stays 11 for the whole unload phase.
- `start` outside IDLE is ignored.
- `in_valid` outside LOAD is ignored and never acknowledged.
- Reset values: state IDLE, `status`=00, `data_in`=0, `data_addr_in`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `run_cycles`=0, counters 0.
- Reset mid-job aborts immediately. The next cycle shows `status`=00 and no pending handshake survives.

## Timing
- All outputs are registered.
- Load byte accepted on edge N appears on `data_in`/`data_addr_in` with `status`=10 after edge N. The processor registers it at edge N+1.
- Back-to-back load handshakes are allowed, one byte per cycle. `status` stays 10 across consecutive accepted bytes.
- Minimum load phase: `LOAD_WORDS`+1 cycles.
- RUN is entered on the edge after LOAD_GAP. The `end_process` response latency is one cycle: `status`=00 on the edge after it is sampled high.
- Unload per byte: 1 (UL_ADDR) + `READ_LAT` + at least 1 (UL_OUT) cycles. `out_valid` is never high for two distinct bytes without an intervening low cycle.
- `out_valid` stays asserted and `out_data` stays stable while `out_ready`=0.

## Structure
- Shared package `proc_pkg`:
  - status encodings `ST_HOLD`=2'b00, `ST_RUN`=2'b01, `ST_LOAD`=2'b10, `ST_UNLOAD`=2'b11 (also used by `processor`);
  - state enum `host_state_t`.
- Single module `dm_host_ctrl`. One natural sub-module, `wait_timer`, for the `READ_LAT` countdown. Inlining it is acceptable.

## Test plan
- Reset mid-RUN after 5 cycles, then `start` again → `status`=00 and `busy`=0 the cycle after reset; `run_cycles`=0; the new job reloads from `LOAD_BASE`.
- `LOAD_WORDS`=4, bytes 11,22,33,44 sent back-to-back → `status`=10 on four consecutive cycles with addresses 0..3 carrying those bytes, then one 00 cycle, then 01.
- Same load with `in_valid` low every other cycle → `status` alternates 10/00 and the addresses/data are still 0..3 in order.
- `end_process` raised 20 cycles into RUN → `run_cycles`=20 and `status`=11 appears with `data_addr_in`=`UNLOAD_BASE`.
- Unload with `UNLOAD_BASE`=16'hFFFF, `UNLOAD_WORDS`=2, DM model returning address low byte after `READ_LAT`=2 → `out_data` FF then 00 (address wraps to 0), then a single `done` pulse.
- `out_ready` held low 10 cycles on the first unload byte → `out_valid` and `out_data` stay stable; the next address is not issued until the handshake.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the processor and its host-side data-memory sequencer.
package proc_pkg;

    // Processor status encodings (shared with processor)
    localparam logic [1:0] ST_HOLD   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_LOAD   = 2'b10;
    localparam logic [1:0] ST_UNLOAD = 2'b11;

    // Host sequencer states
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_LOAD_GAP = 3'd2,
        S_RUN      = 3'd3,
        S_UL_ADDR  = 3'd4,
        S_UL_WAIT  = 3'd5,
        S_UL_OUT   = 3'd6,
        S_DONE     = 3'd7
    } host_state_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Read-latency countdown: reloaded on request, expired once it has run down.
module wait_timer #(
    parameter int unsigned LAT = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic expired_o
);

    localparam logic [15:0] LAT_M1 = 16'(LAT - 1);

    logic [15:0] cnt_q;

    // Reload on request, otherwise count down to zero and hold there
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 16'd0;
        end else if (load_i) begin
            cnt_q <= LAT_M1;
        end else if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    // Expired during the last waiting cycle, so the capture edge lands LAT edges after the address
    assign expired_o = (cnt_q == 16'd0);

endmodule

// File: rtl/dm_host_ctrl.sv
// Host-side sequencer: loads a byte stream into data memory, runs the
// processor until end_process, then streams the result region back out.
module dm_host_ctrl
    import proc_pkg::*;
#(
    parameter logic [15:0] LOAD_BASE    = 16'h0000,
    parameter int unsigned LOAD_WORDS   = 16,
    parameter logic [15:0] UNLOAD_BASE  = 16'h0000,
    parameter int unsigned UNLOAD_WORDS = 16,
    parameter int unsigned READ_LAT     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic [1:0]  status,
    output logic [7:0]  data_in,
    output logic [15:0] data_addr_in,
    input  logic        end_process,
    input  logic [7:0]  dm_out,
    output logic        busy,
    output logic        done,
    output logic [31:0] run_cycles
);

    localparam logic [15:0] LOAD_LAST   = 16'(LOAD_WORDS - 1);
    localparam logic [15:0] UNLOAD_LAST = 16'(UNLOAD_WORDS - 1);

    host_state_t state_q;
    logic [15:0] count_q;
    logic [1:0]  status_q;
    logic [7:0]  data_in_q;
    logic [15:0] addr_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [7:0]  out_data_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] run_cycles_q;
    logic        timer_load_s;
    logic        timer_expired_s;

    // The countdown starts on the edge that registers the unload address
    assign timer_load_s = (state_q == S_UL_ADDR);

    wait_timer #(
        .LAT (READ_LAT)
    ) u_wait_timer (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (timer_load_s),
        .expired_o (timer_expired_s)
    );

    // Sequencer FSM with all interface outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            count_q      <= 16'd0;
            status_q     <= ST_HOLD;
            data_in_q    <= 8'd0;
            addr_q       <= 16'd0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            run_cycles_q <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    status_q <= ST_HOLD;
                    if (start) begin
                        count_q      <= 16'd0;
                        run_cycles_q <= 32'd0;
                        in_ready_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_LOAD;
                    end else begin
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (in_valid && in_ready_q) begin
                        data_in_q <= in_data;
                        addr_q    <= LOAD_BASE + count_q;
                        status_q  <= ST_LOAD;
                        count_q   <= count_q + 16'd1;
                        if (count_q == LOAD_LAST) begin
                            in_ready_q <= 1'b0;
                            state_q    <= S_LOAD_GAP;
                        end
                    end else begin
                        status_q <= ST_HOLD;
                    end
                end
                S_LOAD_GAP: begin
                    // Hold for one cycle so the processor commits the last write
                    status_q <= ST_HOLD;
                    state_q  <= S_RUN;
                end
                S_RUN: begin
                    run_cycles_q <= sat_inc32(run_cycles_q);
                    if (end_process) begin
                        status_q <= ST_HOLD;
                        count_q  <= 16'd0;
                        state_q  <= S_UL_ADDR;
                    end else begin
                        status_q <= ST_RUN;
                    end
                end
                S_UL_ADDR: begin
                    status_q <= ST_UNLOAD;
                    addr_q   <= UNLOAD_BASE + count_q;
                    state_q  <= S_UL_WAIT;
                end
                S_UL_WAIT: begin
                    if (timer_expired_s) begin
                        out_data_q  <= dm_out;
                        out_valid_q <= 1'b1;
                        state_q     <= S_UL_OUT;
                    end
                end
                S_UL_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (count_q == UNLOAD_LAST) begin
                            status_q <= ST_HOLD;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            count_q <= count_q + 16'd1;
                            state_q <= S_UL_ADDR;
                        end
                    end
                end
                S_DONE: begin
                    status_q <= ST_HOLD;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    status_q    <= ST_HOLD;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign status       = status_q;
    assign data_in      = data_in_q;
    assign data_addr_in = addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign run_cycles   = run_cycles_q;

endmodule

// File: tb/tb_dm_host_ctrl.sv
// Self-checking bench for dm_host_ctrl: jobs with random load gaps, run
// lengths and sink stalls, checked against a transaction-level model.
module tb_dm_host_ctrl;

    localparam logic [15:0] LB = 16'h0000;
    localparam int          LW = 4;
    localparam logic [15:0] UB = 16'hFFFF;
    localparam int          UW = 2;
    localparam int          RL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic [1:0]  status;
    logic [7:0]  data_in;
    logic [15:0] data_addr_in;
    logic        end_process = 1'b0;
    logic [7:0]  dm_out;
    logic        busy;
    logic        done;
    logic [31:0] run_cycles;

    int n_checks = 0;
    int n_errors = 0;

    // Data-memory model: content is address low byte xor a per-job key,
    // valid READ_LAT cycles after the address edge (one internal register).
    logic [7:0] dm_key = 8'h00;
    logic [7:0] dm_pipe = 8'h00;

    dm_host_ctrl #(
        .LOAD_BASE    (LB),
        .LOAD_WORDS   (LW),
        .UNLOAD_BASE  (UB),
        .UNLOAD_WORDS (UW),
        .READ_LAT     (RL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .status       (status),
        .data_in      (data_in),
        .data_addr_in (data_addr_in),
        .end_process  (end_process),
        .dm_out       (dm_out),
        .busy         (busy),
        .done         (done),
        .run_cycles   (run_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) dm_pipe <= data_addr_in[7:0] ^ dm_key;
    assign dm_out = dm_pipe;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full job. gap_mode: 0 back-to-back, 1 alternate, 2 random.
    task automatic run_job(input int gap_mode, input int run_len, input int stall_first,
                           input bit abort, input bit fixed);
        logic [7:0]  bytes[$];
        logic [7:0]  key;
        logic [15:0] a;
        logic [7:0]  exp_b;
        bit          v;
        int          acc;
        int          cyc;
        int          w;
        int          stall;

        for (int i = 0; i < LW; i++) begin
            if (fixed) bytes.push_back(8'(8'h11 * (i + 1)));
            else       bytes.push_back(8'($urandom_range(0, 255)));
        end
        key = fixed ? 8'h00 : 8'($urandom_range(0, 255));

        @(negedge clk);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_status", status, 0);
        start  = 1'b1;
        dm_key = key;
        @(negedge clk);
        start = 1'b0;
        check_eq("load_busy", busy, 1);
        check_eq("load_in_ready", in_ready, 1);
        check_eq("run_cycles_clear", run_cycles, 0);

        acc = 0;
        cyc = 0;
        while (acc < LW) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data  = v ? bytes[acc] : 8'($urandom_range(0, 255));
            @(negedge clk);
            if (v) begin
                check_eq("load_status", status, 2);
                check_eq("load_addr", data_addr_in, 32'(16'(LB + 16'(acc))));
                check_eq("load_data", data_in, bytes[acc]);
                acc++;
            end else begin
                check_eq("load_idle_status", status, 0);
            end
            check_eq("load_ready", in_ready, (acc < LW) ? 1 : 0);
            start = (cyc == 1);
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hA5;

        @(negedge clk);
        check_eq("gap_status", status, 0);
        check_eq("gap_in_ready", in_ready, 0);

        for (int c = 2; c <= run_len; c++) begin
            @(negedge clk);
            check_eq("run_status", status, 1);
            check_eq("run_count", run_cycles, c - 1);
            if (abort && c == 6) begin
                rst      = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check_eq("abort_status", status, 0);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_run_cycles", run_cycles, 0);
                check_eq("abort_in_ready", in_ready, 0);
                check_eq("abort_out_valid", out_valid, 0);
                return;
            end
            if (c == run_len) begin
                end_process = 1'b1;
                in_valid    = 1'b0;
            end
        end

        @(negedge clk);
        end_process = 1'b0;
        check_eq("ep_status", status, 0);
        check_eq("ep_run_cycles", run_cycles, run_len);

        for (int k = 0; k < UW; k++) begin
            a     = UB + 16'(k);
            exp_b = a[7:0] ^ key;
            @(negedge clk);
            check_eq("ul_status", status, 3);
            check_eq("ul_addr", data_addr_in, a);
            check_eq("ul_valid_low", out_valid, 0);
            w = 0;
            while (!out_valid && w < RL + 4) begin
                @(negedge clk);
                w++;
            end
            check_eq("ul_latency", w, RL);
            check_eq("ul_data", out_data, exp_b);
            stall = (k == 0) ? stall_first : $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check_eq("stall_valid", out_valid, 1);
                check_eq("stall_data", out_data, exp_b);
                check_eq("stall_addr", data_addr_in, a);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check_eq("hs_valid_drop", out_valid, 0);
            if (k == UW - 1) begin
                check_eq("done_pulse", done, 1);
                check_eq("done_status", status, 0);
            end else begin
                check_eq("no_done", done, 0);
                check_eq("ul_status_hold", status, 3);
            end
        end
        @(negedge clk);
        check_eq("done_drop", done, 0);
        check_eq("end_busy", busy, 0);
        check_eq("end_run_cycles", run_cycles, run_len);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_status", status, 0);
        check_eq("rst_data_in", data_in, 0);
        check_eq("rst_addr", data_addr_in, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_run_cycles", run_cycles, 0);
        rst = 1'b0;

        run_job(0, 20, 10, 1'b0, 1'b1);
        run_job(1, 7, 0, 1'b0, 1'b1);
        run_job(2, 30, 0, 1'b1, 1'b0);
        run_job(0, 12, 2, 1'b0, 1'b0);
        for (int j = 0; j < 6; j++) begin
            run_job($urandom_range(0, 2), $urandom_range(2, 40), $urandom_range(0, 6), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
